l2_responder: RTL

- Lower-level memory responder that serves the L1-to-L2 request channel, i.e. the `req_valid` / `req_type` / `req_fulfilled` handshake that L1 cache controllers drive.
- Holds a word-addressed backing array.
- Services one word per handshake after a fixed, parameterised latency.
- Acts as the L2/memory stand-in for L1 controllers in block and subsystem benches, and as the base for the real L2 controller.

---
 rtl/l2_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/l2_responder.sv
// l2_responder: L2/memory stand-in that serves the L1-to-L2 request channel.
// It holds a word-addressed backing array and completes one word per
// handshake a fixed LATENCY cycles after the request is accepted.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   req_valid      requester holds high while a request is outstanding
//   req_type       LOAD / STORE / CLFLUSH (MO_UNKNOWN is illegal)
//   req_address    byte address; bits [1:0] ignored, word index wraps at MEM_WORDS
//   req_wdata      store data
//   req_rdata      load data, non-zero only while req_fulfilled is high
//   req_fulfilled  one-cycle pulse that completes the accepted request
//   protocol_error sticky error flag, cleared only by reset

package l2_responder_pkg;
    typedef enum logic [1:0] {
        MO_UNKNOWN = 2'd0,
        LOAD       = 2'd1,
        STORE      = 2'd2,
        CLFLUSH    = 2'd3
    } memory_operation_e;
endpackage

module l2_responder
    import l2_responder_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  memory_operation_e req_type,
    input  logic [XLEN-1:0]   req_address,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [XLEN-1:0]   req_rdata,
    output logic              req_fulfilled,
    output logic              protocol_error
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
        $error("l2_responder: MEM_WORDS must be a power of two >= 2");
    end
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("l2_responder: LATENCY must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic              fulfilled_q;
    logic              error_q;
    logic [XLEN-1:0]   rdata_q;

    // Latched request; data-only, so not reset.
    memory_operation_e type_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;

    // Zero at elaboration; deliberately untouched by reset.
    logic [XLEN-1:0]   mem_q [MEM_WORDS] = '{default: '0};

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  lat_idx;
    logic              accept;

    assign req_idx = req_address[IDX_W+1:2];
    assign lat_idx = addr_q[IDX_W+1:2];
    assign accept  = (state_q == ST_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fulfilled_q <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fulfilled_q <= 1'b0;
                    rdata_q     <= '0;
                    if (req_valid) begin
                        if (LATENCY == 1) begin
                            // No wait phase: read straight from the incoming request.
                            state_q     <= ST_RESPOND;
                            fulfilled_q <= 1'b1;
                            rdata_q     <= (req_type == LOAD) ? mem_q[req_idx] : '0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 8'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_valid) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (req_type != type_q || req_address != addr_q) begin
                            error_q <= 1'b1;
                        end
                        // Counter reaching zero lands us in ST_RESPOND exactly
                        // LATENCY cycles after acceptance.
                        if (cnt_q == 8'd1) begin
                            state_q     <= ST_RESPOND;
                            fulfilled_q <= 1'b1;
                            rdata_q     <= (type_q == LOAD) ? mem_q[lat_idx] : '0;
                        end
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_RESPOND: begin
                    state_q     <= ST_IDLE;
                    fulfilled_q <= 1'b0;
                    rdata_q     <= '0;
                    if (req_valid && type_q == MO_UNKNOWN) begin
                        error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            type_q  <= req_type;
            addr_q  <= req_address;
            wdata_q <= req_wdata;
        end
    end

    // Store commits at the end of the respond cycle unless cancelled or reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_RESPOND && req_valid && type_q == STORE) begin
            mem_q[lat_idx] <= wdata_q;
        end
    end

    // A requester dropping valid during the respond cycle cancels the
    // request, so the registered pulse is qualified by valid.
    assign req_fulfilled  = fulfilled_q & req_valid;
    assign req_rdata      = req_fulfilled ? rdata_q : '0;
    assign protocol_error = error_q;

endmodule
